// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential 2-digit BCD to 6-bit binary converter
//
// Purpose: converts packed BCD {tens[2:0], ones[3:0]} to binary with reverse
//   double-dabble, one iteration per clock, six iterations per conversion.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous reset, active-high
//   start   - conversion request, sampled in IDLE or DONE only
//   bcd_in  - packed BCD input, captured when start is accepted
//   busy    - high while iterating (SHIFT)
//   done    - one-cycle pulse, bin_out/err valid from this cycle
//   bin_out - binary result, held until the next conversion completes
//   err     - range error flag, held with bin_out
// Optional feature macro: BCD_RANGE_CHECK_EN (input range checking on err).

module bcd2bin_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] bcd_in,
  output logic       busy,
  output logic       done,
  output logic [5:0] bin_out,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [12:0] work_q, work_d;
  logic [12:0] work_sh;
  logic [5:0]  bin_q, bin_d;

`ifdef BCD_RANGE_CHECK_EN
  logic err_q, err_d;
  logic inv_q, inv_d;
  logic inv_in;

  // tens is 3 bits, so 7 is the only tens value above 6 it can carry.
  assign inv_in = (bcd_in[3:0] > 4'd9) || (bcd_in[6:4] == 3'd7) ||
                  ((bcd_in[6:4] == 3'd6) && (bcd_in[3:0] > 4'd3));
`endif

  // One reverse double-dabble step. The tens LSB shifted into the ones MSB
  // carries weight 5 but lands as 8, hence the subtract-3 correction.
  always_comb begin
    work_sh = work_q >> 1;
    if (work_sh[9:6] >= 4'd8) begin
      work_sh[9:6] = work_sh[9:6] - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bin_d   = bin_q;
`ifdef BCD_RANGE_CHECK_EN
    err_d   = err_q;
    inv_d   = inv_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          work_d  = {bcd_in[6:4], bcd_in[3:0], 6'b0};
          cnt_d   = 3'd0;
          state_d = S_SHIFT;
`ifdef BCD_RANGE_CHECK_EN
          inv_d   = inv_in;
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = work_sh;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = S_DONE;
`ifdef BCD_RANGE_CHECK_EN
          bin_d   = inv_q ? 6'd0 : work_sh[5:0];
          err_d   = inv_q;
`else
          bin_d   = work_sh[5:0];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      work_q  <= 13'd0;
      bin_q   <= 6'd0;
`ifdef BCD_RANGE_CHECK_EN
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bin_q   <= bin_d;
`ifdef BCD_RANGE_CHECK_EN
      err_q   <= err_d;
      inv_q   <= inv_d;
`endif
    end
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign bin_out = bin_q;
`ifdef BCD_RANGE_CHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - scoreboard testbench for bcd2bin_seq

module tb_bcd2bin_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] bcd_in;
  logic       busy;
  logic       done;
  logic [5:0] bin_out;
  logic       err;

  bcd2bin_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int err;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   held_bin = 0;
  int   held_err = 0;
  int   busy_run = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: the binary value of the two decimal digits, wrapped to 6 bits.
  function automatic exp_t model(input logic [6:0] b, input int acc);
    exp_t e;
    int t;
    int o;
    t = int'(b[6:4]);
    o = int'(b[3:0]);
    e.acc = acc;
    e.err = 0;
    e.bin = (t * 10 + o) % 64;
`ifdef BCD_RANGE_CHECK_EN
    if (o > 9 || t == 7 || (t == 6 && o > 3)) begin
      e.err = 1;
      e.bin = 0;
    end
`endif
    return e;
  endfunction

  // Monitor: samples 1ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("bin_out", int'(bin_out), e.bin);
          chk("err", int'(err), e.err);
          chk("latency", cyc - e.acc, 6);
          chk("busy_cycles", busy_run, 6);
        end
        held_bin = int'(bin_out);
        held_err = int'(err);
        busy_run = 0;
      end else begin
        chk("bin_hold", int'(bin_out), held_bin);
        chk("err_hold", int'(err), held_err);
        if (!busy) busy_run = 0;
      end
    end
  end

  // Called at a falling edge while the DUT is in IDLE or DONE.
  task automatic issue(input logic [6:0] b);
    start  = 1'b1;
    bcd_in = b;
    @(negedge clk);
    sb.push_back(model(b, cyc));
    start  = 1'b0;
    bcd_in = 7'($urandom);
    chk("accept_busy", int'(busy), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [6:0] b;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 7'h00;
    idle(2);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_err", int'(err), 0);

    issue(7'h63);
    wait_done();
    idle(2);

    issue(7'h00); wait_done(); idle(1);
    issue(7'h09); wait_done(); idle(1);
    issue(7'h10); wait_done(); idle(1);
    issue(7'h45); wait_done(); idle(1);

    // Back-to-back with an ignored start pulse during SHIFT.
    issue(7'h12);
    idle(1);
    start = 1'b1;
    bcd_in = 7'h33;
    idle(1);
    start = 1'b0;
    wait_done();
    issue(7'h27);
    wait_done();
    idle(2);

    // Input change after acceptance must not matter.
    issue(7'h31);
    bcd_in = 7'h05;
    wait_done();
    idle(2);

    // Reset in the third SHIFT cycle aborts the conversion.
    issue(7'h50);
    idle(2);
    rst = 1'b1;
    sb.delete();
    held_bin = 0;
    held_err = 0;
    idle(1);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bin", int'(bin_out), 0);
    idle(12);

`ifdef BCD_RANGE_CHECK_EN
    issue(7'h64); wait_done(); idle(1);
    issue(7'h0A); wait_done(); idle(1);
    issue(7'h70); wait_done(); idle(1);
    issue(7'h59); wait_done(); idle(1);
`else
    issue(7'h70); wait_done(); idle(1);
`endif

    // All 64 valid inputs, mixing back-to-back and idle gaps.
    for (int v = 0; v < 64; v++) begin
      b = {3'(v / 10), 4'(v % 10)};
      issue(b);
      wait_done();
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
    end
    idle(1);

    // Random raw 7-bit patterns, including out-of-range digits.
    for (int i = 0; i < 30; i++) begin
      issue(7'($urandom));
      wait_done();
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
    end

    idle(10);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
